// File: rtl/div_54by27u_if.sv
// Handshake and data bundle between the datapath and the 54/27 unsigned divider.
// The master drives operands and takes results; the slave is the divider.
interface div_54by27u_if #(
    parameter int DIVIDEND_WIDTH = 54,
    parameter int DIVISOR_WIDTH  = 27
);
    logic                      in_valid;
    logic                      in_ready;
    logic [DIVIDEND_WIDTH-1:0] dividend;
    logic [DIVISOR_WIDTH-1:0]  divisor;
    logic                      out_valid;
    logic                      out_ready;
    logic [DIVIDEND_WIDTH-1:0] quotient;
    logic [DIVISOR_WIDTH-1:0]  remainder;
    logic                      div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_54by27u.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// The dividend register shifts out MSB-first while quotient bits shift in behind it.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   BUSY  | iterating (or one-cycle divide-by-zero fill when dbz_q=1)
//   DONE  | result presented, out_valid=1, held until out_ready
module div_54by27u #(
    parameter int DIVIDEND_WIDTH = 54,
    parameter int DIVISOR_WIDTH  = 27
) (
    input  logic            clk,
    input  logic            rst_n,
    div_54by27u_if.slave    bus
);
    localparam int CW = $clog2(DIVIDEND_WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                    state_q;
    logic [CW-1:0]             count_q;
    logic [DIVIDEND_WIDTH-1:0] quo_q;
    logic [DIVISOR_WIDTH-1:0]  rem_q;
    logic [DIVISOR_WIDTH-1:0]  dvsr_q;
    logic                      dbz_q;

    logic [DIVISOR_WIDTH:0]    rem_shift_d;
    logic [DIVISOR_WIDTH:0]    diff_d;
    logic                      take_d;

    always_comb begin
        rem_shift_d = {rem_q, quo_q[DIVIDEND_WIDTH-1]};
        diff_d      = rem_shift_d - {1'b0, dvsr_q};
        take_d      = ~diff_d[DIVISOR_WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        quo_q   <= bus.dividend;
                        dvsr_q  <= bus.divisor;
                        rem_q   <= '0;
                        state_q <= BUSY;
                        if (bus.divisor == '0) begin
                            dbz_q   <= 1'b1;
                            count_q <= '0;
                        end else begin
                            dbz_q   <= 1'b0;
                            count_q <= CW'(DIVIDEND_WIDTH - 1);
                        end
                    end
                end
                BUSY: begin
                    if (dbz_q) begin
                        // quo_q still holds the untouched dividend here
                        rem_q   <= quo_q[DIVISOR_WIDTH-1:0];
                        quo_q   <= '1;
                        state_q <= DONE;
                    end else begin
                        rem_q   <= take_d ? diff_d[DIVISOR_WIDTH-1:0]
                                          : rem_shift_d[DIVISOR_WIDTH-1:0];
                        quo_q   <= {quo_q[DIVIDEND_WIDTH-2:0], take_d};
                        count_q <= count_q - CW'(1);
                        if (count_q == '0) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
